// File: rtl/spi_flash_fetch.sv
// SPI NOR instruction-fetch master: issues READ (0x03) per program-counter word
// and returns one 16-bit instruction with a single-cycle clk_valid strobe.
module spi_flash_fetch #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [7:0]  READ_CMD   = 8'h03,
    parameter int          CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [15:0]           flash_data,
    output logic                  clk_valid,
    output logic                  busy,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t             state_r;
    logic [31:0]        shift_r;
    logic [14:0]        rx_r;
    logic [5:0]         bit_cnt_r;
    logic               phase_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic               start_s;
    logic               gap_last_s;
    logic [31:0]        start_frame_s;

    // Word address becomes a byte address (pc * 2) zero-extended to 24 bits.
    function automatic logic [31:0] read_frame(input logic [ADDR_WIDTH-1:0] pc);
        return {READ_CMD, {(24-ADDR_WIDTH-1){1'b0}}, pc, 1'b0};
    endfunction

    // Decide whether this edge launches a new transaction.
    always_comb begin
        start_frame_s = read_frame(pc_in);
        gap_last_s    = (gap_cnt_r == GAP_W'(CS_GAP - 1));
        start_s       = 1'b0;
        case (state_r)
            ST_IDLE: start_s = en;
            ST_GAP:  start_s = en & gap_last_s;
            default: start_s = 1'b0;
        endcase
    end

    // Transaction sequencer with registered SPI and core-side outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r    <= ST_IDLE;
            shift_r    <= 32'h0000_0000;
            rx_r       <= 15'h0000;
            bit_cnt_r  <= 6'd0;
            phase_r    <= 1'b0;
            gap_cnt_r  <= '0;
            flash_data <= 16'h0000;
            clk_valid  <= 1'b0;
            busy       <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_sck    <= 1'b0;
            spi_mosi   <= 1'b0;
        end else if (start_s) begin
            state_r   <= ST_START;
            shift_r   <= start_frame_s;
            rx_r      <= 15'h0000;
            bit_cnt_r <= 6'd0;
            phase_r   <= 1'b0;
            gap_cnt_r <= '0;
            clk_valid <= 1'b0;
            busy      <= 1'b1;
            spi_cs_n  <= 1'b0;
            spi_sck   <= 1'b0;
            spi_mosi  <= start_frame_s[31];
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clk_valid <= 1'b0;
                    busy      <= 1'b0;
                    spi_cs_n  <= 1'b1;
                    spi_sck   <= 1'b0;
                end
                ST_START: begin
                    state_r  <= ST_SHIFT;
                    phase_r  <= 1'b0;
                    spi_mosi <= shift_r[31];
                end
                ST_SHIFT: begin
                    if (!phase_r) begin
                        phase_r <= 1'b1;
                        spi_sck <= 1'b1;
                    end else begin
                        phase_r   <= 1'b0;
                        spi_sck   <= 1'b0;
                        rx_r      <= {rx_r[13:0], spi_miso};
                        shift_r   <= {shift_r[30:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                        if (bit_cnt_r == 6'd47) begin
                            state_r    <= ST_DONE;
                            flash_data <= {rx_r, spi_miso};
                            clk_valid  <= 1'b1;
                            spi_cs_n   <= 1'b1;
                            spi_mosi   <= 1'b0;
                        end else begin
                            // Command/address bits precede the 16 data bits, which go out as 0.
                            spi_mosi <= (bit_cnt_r < 6'd31) ? shift_r[30] : 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_GAP;
                    clk_valid <= 1'b0;
                    busy      <= 1'b0;
                    gap_cnt_r <= '0;
                end
                ST_GAP: begin
                    if (gap_last_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    clk_valid <= 1'b0;
                    busy      <= 1'b0;
                    spi_cs_n  <= 1'b1;
                    spi_sck   <= 1'b0;
                    spi_mosi  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_fetch.sv
// Bench for spi_flash_fetch: flash memory model, cycle-offset reference model
// compared every cycle, and directed plus randomized fetch scenarios.
module tb_spi_flash_fetch;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic        en = 1'b0;
    logic [11:0] pc_in = 12'h000;
    logic [15:0] flash_data;
    logic        clk_valid, busy, spi_cs_n, spi_sck, spi_mosi;
    logic        spi_miso;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cv_count = 0;

    logic [7:0]  mem [0:8191];
    logic [31:0] frames [$];

    spi_flash_fetch dut (
        .clk(clk), .arst(arst), .en(en), .pc_in(pc_in),
        .flash_data(flash_data), .clk_valid(clk_valid), .busy(busy),
        .spi_cs_n(spi_cs_n), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] word(input logic [11:0] p);
        logic [12:0] a;
        a = {p, 1'b0};
        return {mem[a], mem[a + 13'd1]};
    endfunction

    function automatic logic flash_bit(input logic [31:0] fr, input int idx);
        logic [12:0] a;
        logic [15:0] pair;
        a = fr[12:0];
        pair = {mem[a], mem[a + 13'd1]};
        return pair[15 - idx];
    endfunction

    function automatic logic [31:0] frame_of(input logic [11:0] p);
        return 32'h0300_0000 | {19'b0, p, 1'b0};
    endfunction

    // Flash device: collect 32 command/address bits, then return data MSB first.
    int          f_cnt;
    logic [31:0] f_sh;
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            f_cnt    <= 0;
            f_sh     <= 32'h0;
            spi_miso <= 1'b0;
        end else begin
            f_cnt <= f_cnt + 1;
            if (f_cnt < 32) begin
                f_sh     <= {f_sh[30:0], spi_mosi};
                spi_miso <= 1'($urandom_range(0, 1));
                if (f_cnt == 31) frames.push_back({f_sh[30:0], spi_mosi});
            end else begin
                spi_miso <= flash_bit(f_sh, f_cnt - 32);
            end
        end
    end

    // Reference model: position t (cycles since START edge) of the current fetch.
    bit          m_active;
    int          m_t;
    logic [11:0] m_pc;
    logic [15:0] m_fd;
    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_pc     <= 12'h0;
            m_fd     <= 16'h0;
        end else if (!m_active) begin
            if (en) begin
                m_active <= 1'b1;
                m_t      <= 0;
                m_pc     <= pc_in;
            end
        end else if (m_t == 99) begin
            if (en) begin
                m_t  <= 0;
                m_pc <= pc_in;
            end else begin
                m_active <= 1'b0;
            end
        end else begin
            m_t <= m_t + 1;
            if (m_t == 96) m_fd <= word(m_pc);
        end
    end

    function automatic logic exp_mosi(input bit act, input int t, input logic [11:0] p);
        logic [31:0] fr;
        int b;
        fr = frame_of(p);
        if (!act || t > 64) return 1'b0;
        b = (t == 0) ? 0 : (t - 1) / 2;
        return fr[31 - b];
    endfunction

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("cs_n",  {31'b0, spi_cs_n},  {31'b0, !(m_active && m_t <= 96)});
        check("sck",   {31'b0, spi_sck},   {31'b0, m_active && m_t >= 2 && m_t <= 96 && (m_t % 2 == 0)});
        check("mosi",  {31'b0, spi_mosi},  {31'b0, exp_mosi(m_active, m_t, m_pc)});
        check("busy",  {31'b0, busy},      {31'b0, m_active && m_t <= 97});
        check("valid", {31'b0, clk_valid}, {31'b0, m_active && m_t == 97});
        check("fdata", {16'b0, flash_data}, {16'b0, m_fd});
        if (clk_valid === 1'b1) cv_count <= cv_count + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cv(output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (clk_valid === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL cv_timeout: got no clk_valid, required one within 400 cycles");
        end
    endtask

    task automatic wait_cs_low(output int c);
        c = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (spi_cs_n === 1'b0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL cs_timeout: got no spi_cs_n low, required one within 400 cycles");
        end
    endtask

    task automatic check_fetch(input logic [11:0] p);
        logic [31:0] f;
        if (frames.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL frame_missing: got no captured frame, required %0h", frame_of(p));
        end else begin
            f = frames.pop_front();
            check("frame", f, frame_of(p));
        end
        check("fetch_data", {16'b0, flash_data}, {16'b0, word(p)});
    endtask

    initial begin
        int s, v, s2, v2, c0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[10] = 8'hA5; mem[11] = 8'h5A;
        mem[8190] = 8'h12; mem[8191] = 8'h34;

        #1 arst = 1'b1;
        tick(3);
        check("rst_fdata", {16'b0, flash_data}, 32'h0);
        check("rst_valid", {31'b0, clk_valid}, 32'h0);
        check("rst_busy",  {31'b0, busy},      32'h0);
        check("rst_cs_n",  {31'b0, spi_cs_n},  32'h1);
        check("rst_sck",   {31'b0, spi_sck},   32'h0);
        check("rst_mosi",  {31'b0, spi_mosi},  32'h0);
        arst = 1'b0;
        tick(2);

        // Basic fetch at pc 5 with literal expectations.
        pc_in = 12'h005; en = 1'b1;
        wait_cs_low(s);
        wait_cv(v);
        check("latency", 32'(v - s), 32'd97);
        check("frame_pc5", (frames.size() > 0) ? frames[0] : 32'hFFFF_FFFF, 32'h0300_000A);
        check("data_pc5", {16'b0, flash_data}, 32'h0000_A55A);
        check_fetch(12'h005);
        wait_cs_low(s2);
        check("restart_gap", 32'(s2 - v), 32'd3);
        en = 1'b0;
        wait_cv(v2);
        check("period", 32'(v2 - v), 32'd100);
        check_fetch(12'h005);
        tick(10);

        // Top of address space: no wrap.
        pc_in = 12'hFFF; en = 1'b1;
        wait_cv(v);
        en = 1'b0;
        check("frame_fff", (frames.size() > 0) ? frames[0] : 32'hFFFF_FFFF, 32'h0300_1FFE);
        check("data_fff", {16'b0, flash_data}, 32'h0000_1234);
        check_fetch(12'hFFF);
        tick(5);

        // Back-to-back with the PC advancing on each strobe.
        pc_in = 12'h000; en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v2 = v;
            wait_cv(v);
            if (k > 0) check("b2b_period", 32'(v - v2), 32'd100);
            check_fetch(12'(k));
            pc_in = pc_in + 12'h001;
        end
        en = 1'b0;
        tick(5);

        // PC wiggles during SHIFT are ignored.
        pc_in = 12'h123; en = 1'b1;
        wait_cs_low(s);
        tick(30);
        for (int k = 0; k < 10; k++) begin
            pc_in = 12'($urandom_range(0, 4095));
            tick(1);
        end
        en = 1'b0;
        wait_cv(v);
        check_fetch(12'h123);
        tick(5);

        // en dropped around bit 20: transaction completes once, then idle.
        pc_in = 12'h0AB; en = 1'b1;
        wait_cs_low(s);
        tick(40);
        en = 1'b0;
        c0 = cv_count;
        wait_cv(v);
        check_fetch(12'h0AB);
        tick(250);
        check("en_drop_pulses", 32'(cv_count - c0), 32'd1);
        check("en_drop_cs_n", {31'b0, spi_cs_n}, 32'h1);

        // Reset pulsed around bit 30.
        pc_in = 12'h03C; en = 1'b1;
        wait_cs_low(s);
        tick(61);
        #2 arst = 1'b1;
        #1;
        check("arst_cs_n",  {31'b0, spi_cs_n},  32'h1);
        check("arst_sck",   {31'b0, spi_sck},   32'h0);
        check("arst_fdata", {16'b0, flash_data}, 32'h0);
        check("arst_valid", {31'b0, clk_valid}, 32'h0);
        c0 = cv_count;
        @(negedge clk);
        arst = 1'b0;
        check("arst_no_frame", 32'(frames.size()), 32'd0);
        wait_cv(v);
        check_fetch(12'h03C);
        en = 1'b0;
        tick(1);
        check("arst_pulses", 32'(cv_count - c0), 32'd1);
        tick(5);

        // Randomized fetches with random en drops.
        for (int i = 0; i < 8; i++) begin
            pc_in = 12'($urandom_range(0, 4095));
            en = 1'b1;
            wait_cv(v);
            check_fetch(pc_in);
            if ($urandom_range(0, 1) == 1) begin
                pc_in = 12'($urandom_range(0, 4095));
                en = 1'b0;
                tick($urandom_range(0, 5));
            end
        end
        en = 1'b0;
        tick(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
